// File: rtl/alarm_ring_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alarm_ring_ctrl
// Purpose  : Alarm match detection, ring/snooze/stop state machine, beat
//            clock (music_clk) and square-wave melody (speaker) generation.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_ring_ctrl #(
  parameter int BEAT_HALF  = 25_000_000,
  parameter int SNOOZE_SEC = 300,
  parameter int RING_SEC   = 600,
  parameter int NOTE0      = 113636,
  parameter int NOTE1      = 101239,
  parameter int NOTE2      = 90193,
  parameter int NOTE3      = 85131,
  parameter int NOTE4      = 75843,
  parameter int NOTE5      = 67568,
  parameter int NOTE6      = 60197,
  parameter int NOTE7      = 56818
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sec_tick,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       stop,
  output logic       turned_on,
  output logic       music_clk,
  output logic       speaker,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RINGING = 2'b01,
    S_SNOOZE  = 2'b10
  } state_t;

  function automatic int f_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int C_NOTE_MAX = f_max(f_max(f_max(NOTE0, NOTE1), f_max(NOTE2, NOTE3)),
                                    f_max(f_max(NOTE4, NOTE5), f_max(NOTE6, NOTE7)));

  // Widths never drop below one bit so degenerate parameter values still elaborate.
  localparam int C_BEAT_W = (BEAT_HALF > 1) ? $clog2(BEAT_HALF) : 1;
  localparam int C_RING_W = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
  // The snooze counter is loaded with SNOOZE_SEC itself, so it needs room for that value.
  localparam int C_SNZ_W  = (SNOOZE_SEC > 0) ? $clog2(SNOOZE_SEC + 1) : 1;
  localparam int C_TONE_W = (C_NOTE_MAX > 1) ? $clog2(C_NOTE_MAX) : 1;

  localparam logic [C_BEAT_W-1:0] C_BEAT_LAST = C_BEAT_W'(BEAT_HALF - 1);
  localparam logic [C_RING_W-1:0] C_RING_LAST = C_RING_W'(RING_SEC - 1);
  localparam logic [C_SNZ_W-1:0]  C_SNZ_LOAD  = C_SNZ_W'(SNOOZE_SEC);
  localparam logic [C_SNZ_W-1:0]  C_SNZ_ONE   = C_SNZ_W'(1);

  state_t                r_state;
  logic                  r_turned_on;
  logic                  r_music_clk;
  logic                  r_speaker;
  logic [C_BEAT_W-1:0]   r_beat_cnt;
  logic [2:0]            r_step;
  logic [C_TONE_W-1:0]   r_tone_cnt;
  logic [C_RING_W-1:0]   r_ring_cnt;
  logic [C_SNZ_W-1:0]    r_snz_cnt;

  state_t                w_next;
  logic                  w_match;
  logic                  w_abort;
  logic                  w_ring_last;
  logic                  w_snz_last;
  logic                  w_run_ring;
  logic                  w_beat_wrap;
  logic                  w_step_adv;
  logic                  w_tone_wrap;
  logic [C_TONE_W-1:0]   w_note_last;

  // Only the tick at second 0 can match, so a stop inside the alarm minute cannot retrigger.
  assign w_match     = sec_tick & alarm_en & (cur_sec == 6'd0) &
                       (cur_hour == alarm_hour) & (cur_min == alarm_min);
  assign w_abort     = stop | ~alarm_en;
  assign w_ring_last = (r_ring_cnt == C_RING_LAST);
  assign w_snz_last  = (r_snz_cnt == C_SNZ_ONE);
  assign w_beat_wrap = (r_beat_cnt == C_BEAT_LAST);
  // A beat wrap while music_clk is low is the rising edge that advances the melody.
  assign w_step_adv  = w_beat_wrap & ~r_music_clk;
  assign w_tone_wrap = (r_tone_cnt == w_note_last);

  // Next-state logic: stop/disable beats snooze, snooze beats the second-count timeouts.
  always_comb begin
    w_next     = r_state;
    w_run_ring = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_match) w_next = S_RINGING;
      end
      S_RINGING: begin
        if (w_abort)                     w_next = S_IDLE;
        else if (snooze)                 w_next = S_SNOOZE;
        else if (sec_tick && w_ring_last) w_next = S_IDLE;
        // Tone/beat generators only run while staying in RINGING; entry clears them.
        w_run_ring = (w_next == S_RINGING);
      end
      S_SNOOZE: begin
        if (w_abort)                    w_next = S_IDLE;
        else if (sec_tick && w_snz_last) w_next = S_RINGING;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Half-period lookup for the current melody step.
  always_comb begin
    w_note_last = C_TONE_W'(NOTE0 - 1);
    case (r_step)
      3'd0: w_note_last = C_TONE_W'(NOTE0 - 1);
      3'd1: w_note_last = C_TONE_W'(NOTE1 - 1);
      3'd2: w_note_last = C_TONE_W'(NOTE2 - 1);
      3'd3: w_note_last = C_TONE_W'(NOTE3 - 1);
      3'd4: w_note_last = C_TONE_W'(NOTE4 - 1);
      3'd5: w_note_last = C_TONE_W'(NOTE5 - 1);
      3'd6: w_note_last = C_TONE_W'(NOTE6 - 1);
      3'd7: w_note_last = C_TONE_W'(NOTE7 - 1);
      default: w_note_last = C_TONE_W'(NOTE0 - 1);
    endcase
  end

  // State register and the registered alarm-active flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_turned_on <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_turned_on <= (w_next == S_RINGING);
    end
  end

  // Ring-duration and snooze-duration second counters, both saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
    end else begin
      if (w_run_ring) begin
        if (sec_tick && !w_ring_last) r_ring_cnt <= r_ring_cnt + C_RING_W'(1);
      end else begin
        r_ring_cnt <= '0;
      end

      if (w_next == S_SNOOZE) begin
        if (r_state != S_SNOOZE)                r_snz_cnt <= C_SNZ_LOAD;
        else if (sec_tick && r_snz_cnt != '0)   r_snz_cnt <= r_snz_cnt - C_SNZ_W'(1);
      end else begin
        r_snz_cnt <= '0;
      end
    end
  end

  // Beat generator: music_clk toggles every BEAT_HALF cycles; each rise advances the melody.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_beat_cnt  <= '0;
      r_music_clk <= 1'b0;
      r_step      <= 3'd0;
    end else if (!w_run_ring) begin
      r_beat_cnt  <= '0;
      r_music_clk <= 1'b0;
      r_step      <= 3'd0;
    end else if (w_beat_wrap) begin
      r_beat_cnt  <= '0;
      r_music_clk <= ~r_music_clk;
      if (!r_music_clk) r_step <= r_step + 3'd1;
    end else begin
      r_beat_cnt  <= r_beat_cnt + C_BEAT_W'(1);
    end
  end

  // Tone generator: a step change restarts the half-period and holds the speaker level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tone_cnt <= '0;
      r_speaker  <= 1'b0;
    end else if (!w_run_ring) begin
      r_tone_cnt <= '0;
      r_speaker  <= 1'b0;
    end else if (w_step_adv) begin
      r_tone_cnt <= '0;
    end else if (w_tone_wrap) begin
      r_tone_cnt <= '0;
      r_speaker  <= ~r_speaker;
    end else begin
      r_tone_cnt <= r_tone_cnt + C_TONE_W'(1);
    end
  end

  assign turned_on = r_turned_on;
  assign music_clk = r_music_clk;
  assign speaker   = r_speaker;
  assign state_o   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ring_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_ring_ctrl
// Purpose  : Scoreboard bench for alarm_ring_ctrl with small sim parameters
//            (BEAT_HALF=4, SNOOZE_SEC=3, RING_SEC=5, NOTEn=n+2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_ring_ctrl;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RING = 2'b01;
  localparam logic [1:0] ST_SNZ  = 2'b10;

  // Field mask: [3] state, [2] turned_on, [1] music_clk, [0] speaker
  localparam logic [3:0] M_ALL = 4'b1111;
  localparam logic [3:0] M_ST  = 4'b1100;
  localparam logic [3:0] M_STM = 4'b1110;

  typedef struct {
    int         cyc;
    string      tag;
    logic [1:0] st;
    logic       ton;
    logic       mclk;
    logic       spk;
    logic [3:0] mask;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sec_tick;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_en;
  logic       snooze;
  logic       stop;
  logic       w_turned_on;
  logic       w_music_clk;
  logic       w_speaker;
  logic [1:0] w_state;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  exp_t m_e;

  alarm_ring_ctrl #(
    .BEAT_HALF (4), .SNOOZE_SEC(3), .RING_SEC(5),
    .NOTE0(2), .NOTE1(3), .NOTE2(4), .NOTE3(5),
    .NOTE4(6), .NOTE5(7), .NOTE6(8), .NOTE7(9)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sec_tick   (sec_tick),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .cur_sec    (cur_sec),
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .alarm_en   (alarm_en),
    .snooze     (snooze),
    .stop       (stop),
    .turned_on  (w_turned_on),
    .music_clk  (w_music_clk),
    .speaker    (w_speaker),
    .state_o    (w_state)
  );

  always #5 clk = ~clk;

  // Cycle index: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string tag, input string fld, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s.%s actual=%0d required=%0d (cycle %0d)", tag, fld, act, req, cyc);
    end
  endfunction

  task automatic push_exp(input string tag, input int dly, input logic [1:0] st,
                          input logic ton, input logic mclk, input logic spk,
                          input logic [3:0] mask);
    exp_t e;
    e.cyc = cyc + dly; e.tag = tag; e.st = st;
    e.ton = ton; e.mclk = mclk; e.spk = spk; e.mask = mask;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present 07:30:00 with a second tick; RINGING is expected after the next edge.
  task automatic do_match(input string tag);
    cur_hour = 5'd7; cur_min = 6'd30; cur_sec = 6'd0; sec_tick = 1'b1;
    push_exp(tag, 1, ST_RING, 1'b1, 1'b0, 1'b0, M_ALL);
    tick();
    sec_tick = 1'b0; cur_sec = 6'd1;
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      if (m_e.cyc < cyc) begin
        chk(m_e.tag, "missed_cycle", cyc, m_e.cyc);
      end else begin
        if (m_e.mask[3]) chk(m_e.tag, "state_o",   int'(w_state),     int'(m_e.st));
        if (m_e.mask[2]) chk(m_e.tag, "turned_on", int'(w_turned_on), int'(m_e.ton));
        if (m_e.mask[1]) chk(m_e.tag, "music_clk", int'(w_music_clk), int'(m_e.mclk));
        if (m_e.mask[0]) chk(m_e.tag, "speaker",   int'(w_speaker),   int'(m_e.spk));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; sec_tick = 1'b0; snooze = 1'b0; stop = 1'b0;
    alarm_en = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd30;
    cur_hour = 5'd7; cur_min = 6'd29; cur_sec = 6'd59;

    push_exp("reset", 1, ST_IDLE, 1'b0, 1'b0, 1'b0, M_ALL);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // One second before the alarm: nothing happens
    sec_tick = 1'b1;
    push_exp("pre_match", 1, ST_IDLE, 1'b0, 1'b0, 1'b0, M_ALL);
    tick();

    // Match, then beat/tone timing: music rises 4 cycles after entry, speaker after 2
    do_match("match");
    for (int i = 1; i <= 5; i++) begin
      if (i <= 3) push_exp("beat_tone", i, ST_RING, 1'b1, 1'b0, (i >= 2), M_ALL);
      else        push_exp("beat_hi",   i, ST_RING, 1'b1, 1'b1, 1'b0, M_STM);
    end
    repeat (5) tick();

    // Stop while music_clk is high
    stop = 1'b1;
    push_exp("stop", 1, ST_IDLE, 1'b0, 1'b0, 1'b0, M_ALL);
    tick();
    stop = 1'b0;

    // Remaining ticks of the alarm minute do not retrigger
    for (int s = 1; s <= 3; s++) begin
      cur_sec = 6'(s); sec_tick = 1'b1;
      push_exp("no_retrigger", 1, ST_IDLE, 1'b0, 1'b0, 1'b0, M_ALL);
      tick(); sec_tick = 1'b0; tick();
    end

    // Near-miss patterns: wrong minute, wrong hour, disarmed, no tick
    cur_hour = 5'd7; cur_min = 6'd31; cur_sec = 6'd0; sec_tick = 1'b1;
    push_exp("min_mismatch", 1, ST_IDLE, 1'b0, 1'b0, 1'b0, M_ALL);
    tick();
    cur_hour = 5'd8; cur_min = 6'd30;
    push_exp("hour_mismatch", 1, ST_IDLE, 1'b0, 1'b0, 1'b0, M_ALL);
    tick();
    cur_hour = 5'd7; alarm_en = 1'b0;
    push_exp("disarmed", 1, ST_IDLE, 1'b0, 1'b0, 1'b0, M_ALL);
    tick();
    alarm_en = 1'b1; sec_tick = 1'b0;
    push_exp("no_tick", 1, ST_IDLE, 1'b0, 1'b0, 1'b0, M_ALL);
    tick();

    // Snooze, three seconds, back to RINGING with the melody at step 0
    do_match("match_snz");
    tick();
    snooze = 1'b1;
    push_exp("snooze", 1, ST_SNZ, 1'b0, 1'b0, 1'b0, M_ALL);
    tick();
    snooze = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      cur_sec = 6'(n + 10); sec_tick = 1'b1;
      if (n < 3) push_exp("snz_count", 1, ST_SNZ,  1'b0, 1'b0, 1'b0, M_ALL);
      else       push_exp("re_ring",   1, ST_RING, 1'b1, 1'b0, 1'b0, M_ALL);
      tick();
      sec_tick = 1'b0;
      if (n < 3) tick();
    end
    for (int i = 1; i <= 3; i++)
      push_exp("re_ring_step0", i, ST_RING, 1'b1, 1'b0, (i >= 2), M_ALL);
    repeat (3) tick();

    // Auto-stop after five seconds of ringing
    for (int n = 1; n <= 5; n++) begin
      sec_tick = 1'b1;
      if (n < 5) push_exp("ring_count", 1, ST_RING, 1'b1, 1'b0, 1'b0, M_ST);
      else       push_exp("ring_timeout", 1, ST_IDLE, 1'b0, 1'b0, 1'b0, M_ALL);
      tick(); sec_tick = 1'b0; tick();
    end

    // Snooze wins over the final-second timeout; match ignored in SNOOZE; stop from SNOOZE
    do_match("match_prio");
    for (int n = 1; n <= 4; n++) begin
      sec_tick = 1'b1;
      push_exp("ring_count2", 1, ST_RING, 1'b1, 1'b0, 1'b0, M_ST);
      tick(); sec_tick = 1'b0; tick();
    end
    sec_tick = 1'b1; snooze = 1'b1;
    push_exp("snooze_over_timeout", 1, ST_SNZ, 1'b0, 1'b0, 1'b0, M_ALL);
    tick();
    snooze = 1'b0;
    cur_sec = 6'd0;
    push_exp("match_in_snooze", 1, ST_SNZ, 1'b0, 1'b0, 1'b0, M_ALL);
    tick();
    sec_tick = 1'b0; cur_sec = 6'd1; stop = 1'b1;
    push_exp("stop_in_snooze", 1, ST_IDLE, 1'b0, 1'b0, 1'b0, M_ALL);
    tick();
    stop = 1'b0;

    // Snooze and stop together: stop wins
    do_match("match_both");
    tick();
    snooze = 1'b1; stop = 1'b1;
    push_exp("snooze_and_stop", 1, ST_IDLE, 1'b0, 1'b0, 1'b0, M_ALL);
    tick();
    snooze = 1'b0; stop = 1'b0;

    // Disarming while ringing
    do_match("match_dis");
    tick();
    alarm_en = 1'b0;
    push_exp("disarm_ringing", 1, ST_IDLE, 1'b0, 1'b0, 1'b0, M_ALL);
    tick();
    alarm_en = 1'b1;

    // Asynchronous reset while music_clk is high
    do_match("match_rst");
    push_exp("pre_reset_hi", 4, ST_RING, 1'b1, 1'b1, 1'b0, M_STM);
    repeat (5) tick();
    reset_n = 1'b0;
    push_exp("async_reset", 0, ST_IDLE, 1'b0, 1'b0, 1'b0, M_ALL);
    tick(); tick();
    reset_n = 1'b1;
    cur_sec = 6'd5; sec_tick = 1'b1;
    push_exp("post_reset_idle", 1, ST_IDLE, 1'b0, 1'b0, 1'b0, M_ALL);
    tick();
    sec_tick = 1'b0;
    tick();
    do_match("match_after_rst");
    tick();

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alarm_ring_ctrl.md
Name: alarm_ring_ctrl

Overview:
- Source side of the alarm indication interface. Detects the alarm-time match and drives `turned_on` (alarm active) and `music_clk` (beat clock) to the light block.
- Also produces the `speaker` square-wave melody.
- Owns the ring / snooze / stop state machine. Sits between the timekeeping counters and the light and audio outputs.

Parameters:
- BEAT_HALF, 25_000_000, clk cycles per half beat of `music_clk` (100 MHz gives a 2 Hz beat).
- SNOOZE_SEC, 300, seconds spent in SNOOZE before re-ringing.
- RING_SEC, 600, seconds of continuous ringing before auto-stop.
- NOTE0..NOTE7, 113636/101239/90193/85131/75843/67568/60197/56818, `speaker` half-period in clk cycles for melody step 0..7.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- sec_tick  in  1  one-cycle pulse, once per second
- cur_hour  in  5  current hour, 0-23
- cur_min  in  6  current minute, 0-59
- cur_sec  in  6  current second, 0-59
- alarm_hour  in  5  alarm hour
- alarm_min  in  6  alarm minute
- alarm_en  in  1  alarm armed (level)
- snooze  in  1  one-cycle pulse, debounced upstream
- stop  in  1  one-cycle pulse, debounced upstream
- turned_on  out  1  high while RINGING
- music_clk  out  1  beat square wave
- speaker  out  1  tone square wave
- state_o  out  2  00 IDLE, 01 RINGING, 10 SNOOZE

Behaviour:
- Reset (reset_n=0, asynchronous): state IDLE; `turned_on`, `music_clk` and `speaker` = 0; all counters = 0.
- All outputs are registered.
- Match condition: `sec_tick & alarm_en & cur_sec==0 & cur_hour==alarm_hour & cur_min==alarm_min`.
  - It can be true at most once per minute, so a stop inside the matching minute does not retrigger.
- IDLE -> RINGING on match. Next cycle: `turned_on`=1, beat and note counters cleared, `ring_cnt`=0.
- RINGING:
  - `stop`, or `alarm_en`=0 -> IDLE.
  - Else `snooze` -> SNOOZE, with `snz_cnt` loaded with SNOOZE_SEC.
  - Else on `sec_tick`, `ring_cnt`++. When `ring_cnt` reaches RING_SEC-1 and `sec_tick` is high -> IDLE.
  - Match events while RINGING are ignored.
- SNOOZE:
  - `stop`, or `alarm_en`=0 -> IDLE.
  - On `sec_tick`, `snz_cnt`--. When `snz_cnt`==1 and `sec_tick` is high -> RINGING; `ring_cnt` is reset and the melody restarts at step 0.
  - `snooze` and match events are ignored.
- Priority when events coincide: `stop` / `!alarm_en` > `snooze` > timeout / sec-count. Reset overrides everything mid-operation.
- `music_clk`:
  - In RINGING only, a counter runs 0..BEAT_HALF-1 and toggles `music_clk` on wrap.
  - The first rising edge occurs exactly BEAT_HALF cycles after entering RINGING.
  - On leaving RINGING, `music_clk` is forced to 0 on the next cycle and the counter is cleared.
- Melody step:
  - 3-bit counter, incremented on each `music_clk` rising edge (every 2*BEAT_HALF cycles).
  - Wraps 7 -> 0.
  - Cleared on entry to RINGING.
- `speaker`:
  - In RINGING, a tone counter runs 0..NOTEn-1 for the current step n and toggles `speaker` on wrap.
  - On a step change, the tone counter restarts at 0.
  - Outside RINGING, `speaker`=0.
- Width rules:
  - Counters are sized to $clog2 of their parameter.
  - `ring_cnt` and `snz_cnt` saturate; they never wrap.
  - Comparisons use zero-extended operands.

Test Plan:
- Sim params BEAT_HALF=4, SNOOZE_SEC=3, RING_SEC=5, NOTEn=n+2. `alarm`=07:30, `alarm_en`=1, time 07:30:00 with `sec_tick` -> `turned_on`=1 next cycle, `state_o`=01, first `music_clk` rise 4 cycles later, period 8 cycles.
- Ringing, then `stop` pulse -> `turned_on`, `music_clk` and `speaker` all 0 one cycle later. Further ticks at 07:30:01..07:30:59 -> stays IDLE.
- Ringing, then `snooze` -> `state_o`=10, `turned_on`=0. After 3 `sec_tick`s -> `state_o`=01 and melody step=0.
- Ringing with no input -> after 5 `sec_tick`s, `state_o`=00.
- `snooze` and `stop` in the same cycle while RINGING -> IDLE, not SNOOZE.
- `reset_n` pulled low mid-RINGING while `music_clk`=1 -> all outputs 0 immediately, without waiting for a clock edge. After release, stays IDLE until the next match.
